// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer.
// Exports: state_e (ST_DATA, ST_PARITY), cnt_width() for the Bit_Count width,
// even_parity() for the optional parity check (SIPO_PARITY_EN).
package sipo_pkg;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_e;

    // Bit_Count must be able to hold the value WIDTH (reached in PARITY).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Even parity of a word: 1 when the word holds an odd number of ones.
    // Callers zero-extend the word to 64 bits; extra zeros do not change parity.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register with valid/ready handshake and overrun detection.
// Latency: loaded word visible the cycle after load_vld_i; overrun_o pulses aligned with the dropped load.
// Backpressure: a load is taken when empty or draining this cycle, otherwise the word is dropped.
// Ports: clk_i/rst_n_i (async active-low), load_vld_i/load_dat_i (completed word),
//        out_rdy_i (consumer accept), out_dat_o/out_vld_o (held word), overrun_o (pulse).
module sipo_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_vld_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_dat_o,
    output logic             out_vld_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] dat_q, dat_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;
    logic             can_load;

    // Room exists if empty, or if the current word is consumed on this same edge.
    assign can_load = !vld_q || out_rdy_i;

    always_comb begin
        dat_d = dat_q;
        vld_d = vld_q;
        ovr_d = 1'b0;
        if (load_vld_i && can_load) begin
            dat_d = load_dat_i;
            vld_d = 1'b1;
        end else begin
            if (load_vld_i) begin
                ovr_d = 1'b1;
            end
            if (vld_q && out_rdy_i) begin
                vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dat_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign out_dat_o = dat_q;
    assign out_vld_o = vld_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer: assembles WIDTH qualified serial bits into a word.
// Latency: word and Out_Valid update on the edge sampling the final bit (data, or parity with SIPO_PARITY_EN).
// Backpressure: Out_Valid/Out_Ready; a word completing into a full, undrained holding register is dropped (Overrun).
// Ports: Clk, Rst_n (async active-low), Serial_In/In_Valid (serial bit), Clear (abort partial word),
//        Parallel_Out/Out_Valid/Out_Ready (word handshake), Bit_Count, Overrun, Parity_Err (pulses).
// Optional feature: define SIPO_PARITY_EN to add an even-parity bit after each word.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Serial_In,
    input  logic                          In_Valid,
    input  logic                          Clear,
    output logic [WIDTH-1:0]              Parallel_Out,
    output logic                          Out_Valid,
    input  logic                          Out_Ready,
    output logic [cnt_width(WIDTH)-1:0]   Bit_Count,
    output logic                          Overrun,
    output logic                          Parity_Err
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic             word_vld;
    logic [WIDTH-1:0] word_dat;
`ifdef SIPO_PARITY_EN
    logic             perr_d, perr_q;
`endif

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shift_q[WIDTH-2:0], Serial_In};
        end else begin
            shifted = {Serial_In, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        word_vld = 1'b0;
        word_dat = shifted;
`ifdef SIPO_PARITY_EN
        perr_d   = 1'b0;
`endif
        if (Clear) begin
            // Abort wins over the bit on this edge; shift contents are flushed by the next frame.
            cnt_d   = '0;
            state_d = ST_DATA;
        end else if (In_Valid) begin
            case (state_q)
                ST_DATA: begin
                    shift_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_PARITY;
`else
                        cnt_d    = '0;
                        word_vld = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`ifdef SIPO_PARITY_EN
                ST_PARITY: begin
                    // The shift register already holds the full word; this bit is parity only.
                    word_dat = shift_q;
                    word_vld = 1'b1;
                    perr_d   = even_parity(64'(shift_q)) != Serial_In;
                    cnt_d    = '0;
                    state_d  = ST_DATA;
                end
`endif
                default: begin
                    state_d = ST_DATA;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_DATA;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign Parity_Err = perr_q;
`else
    assign Parity_Err = 1'b0;
`endif

    sipo_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_i      (Clk),
        .rst_n_i    (Rst_n),
        .load_vld_i (word_vld),
        .load_dat_i (word_dat),
        .out_rdy_i  (Out_Ready),
        .out_dat_o  (Parallel_Out),
        .out_vld_o  (Out_Valid),
        .overrun_o  (Overrun)
    );

    assign Bit_Count = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: two instances (MSB-first and LSB-first) share
// one stimulus stream; a queue-based frame model predicts every output each cycle, and
// directed literal checks pin the model on the documented scenarios.
// Honours SIPO_PARITY_EN in the same way as the design.
module tb_sipo_deserializer;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = W;
    localparam bit PAR   = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic Serial_In = 1'b0;
    logic In_Valid = 1'b0;
    logic Clear = 1'b0;
    logic Out_Ready = 1'b0;

    logic [W-1:0] po_m, po_l;
    logic         ov_m, ov_l;
    logic [2:0]   bc_m, bc_l;
    logic         orun_m, orun_l;
    logic         pe_m, pe_l;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .Clk(Clk), .Rst_n(Rst_n), .Serial_In(Serial_In), .In_Valid(In_Valid), .Clear(Clear),
        .Parallel_Out(po_m), .Out_Valid(ov_m), .Out_Ready(Out_Ready), .Bit_Count(bc_m),
        .Overrun(orun_m), .Parity_Err(pe_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .Clk(Clk), .Rst_n(Rst_n), .Serial_In(Serial_In), .In_Valid(In_Valid), .Clear(Clear),
        .Parallel_Out(po_l), .Out_Valid(ov_l), .Out_Ready(Out_Ready), .Bit_Count(bc_l),
        .Overrun(orun_l), .Parity_Err(pe_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         q_bits[$];
    logic       m_vld = 1'b0;
    logic [W-1:0] m_dat_m = '0;
    logic [W-1:0] m_dat_l = '0;
    logic       m_ovr = 1'b0;
    logic       m_perr = 1'b0;

    always @(posedge Clk) begin
        logic old_vld;
        logic loaded;
        int   ones;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
        if (!Rst_n) begin
            q_bits.delete();
            m_vld   = 1'b0;
            m_dat_m = '0;
            m_dat_l = '0;
        end else begin
            old_vld = m_vld;
            loaded  = 1'b0;
            if (Clear) begin
                q_bits.delete();
            end else if (In_Valid) begin
                q_bits.push_back(Serial_In);
                if (q_bits.size() == FRAME) begin
                    ones = 0;
                    for (int i = 0; i < W; i++) begin
                        ones += int'(q_bits[i]);
                    end
                    if (PAR) begin
                        if ((ones % 2) != int'(q_bits[FRAME-1])) m_perr = 1'b1;
                    end
                    if (!old_vld || Out_Ready) begin
                        for (int i = 0; i < W; i++) begin
                            m_dat_m[W-1-i] = q_bits[i];
                            m_dat_l[i]     = q_bits[i];
                        end
                        m_vld  = 1'b1;
                        loaded = 1'b1;
                    end else begin
                        m_ovr = 1'b1;
                    end
                    q_bits.delete();
                end
            end
            if (!loaded && old_vld && Out_Ready) m_vld = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge Clk) begin
        #1;
        chk("po_msb",   32'(po_m),   32'(m_dat_m));
        chk("po_lsb",   32'(po_l),   32'(m_dat_l));
        chk("vld_msb",  32'(ov_m),   32'(m_vld));
        chk("vld_lsb",  32'(ov_l),   32'(m_vld));
        chk("cnt_msb",  32'(bc_m),   32'(q_bits.size()));
        chk("cnt_lsb",  32'(bc_l),   32'(q_bits.size()));
        chk("ovr_msb",  32'(orun_m), 32'(m_ovr));
        chk("ovr_lsb",  32'(orun_l), 32'(m_ovr));
        chk("perr_msb", 32'(pe_m),   32'(m_perr));
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic iv, input logic rdy, input logic clr);
        @(negedge Clk);
        Serial_In = s;
        In_Valid  = iv;
        Out_Ready = rdy;
        Clear     = clr;
        @(posedge Clk);
        #2;
    endtask

    // Sends a word first bit = w[W-1]; with parity adds the even-parity bit, inverted if bad.
    task automatic send_word(input logic [W-1:0] w, input logic rdy_last, input logic bad);
        for (int i = W - 1; i >= 0; i--) begin
            cyc(w[i], 1'b1, (i == 0 && !PAR) ? rdy_last : 1'b0, 1'b0);
        end
        if (PAR) cyc((^w) ^ bad, 1'b1, rdy_last, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #2;
        chk("rst_po",   32'(po_m),   32'h0);
        chk("rst_vld",  32'(ov_m),   32'h0);
        chk("rst_cnt",  32'(bc_m),   32'h0);
        chk("rst_ovr",  32'(orun_m), 32'h0);
        chk("rst_perr", 32'(pe_m),   32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // 1,0,1,0
        send_word(4'b1010, 1'b0, 1'b0);
        chk("w1010_msb", 32'(po_m), 32'hA);
        chk("w1010_lsb", 32'(po_l), 32'h5);
        chk("w1010_vld", 32'(ov_m), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_vld", 32'(ov_m), 32'h0);

        // 1,1,0,0
        send_word(4'b1100, 1'b0, 1'b0);
        chk("w1100_lsb", 32'(po_l), 32'h3);
        chk("w1100_msb", 32'(po_m), 32'hC);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: two words with no consumer
        send_word(4'b1010, 1'b0, 1'b0);
        send_word(4'b1100, 1'b0, 1'b0);
        chk("ovr_pulse", 32'(orun_m), 32'h1);
        chk("ovr_keep",  32'(po_m),   32'hA);
        chk("ovr_vld",   32'(ov_m),   32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_once",  32'(orun_m), 32'h0);

        // Drain and load on the same edge
        send_word(4'b1111, 1'b1, 1'b0);
        chk("same_po",  32'(po_m),   32'hF);
        chk("same_vld", 32'(ov_m),   32'h1);
        chk("same_ovr", 32'(orun_m), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Clear after two bits
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_clr_cnt", 32'(bc_m), 32'h2);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_cnt", 32'(bc_m), 32'h0);
        send_word(4'b0101, 1'b0, 1'b0);
        chk("clr_po", 32'(po_m), 32'h5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-word
        send_word(4'b1001, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_po",  32'(po_m), 32'h0);
        chk("arst_vld", 32'(ov_m), 32'h0);
        chk("arst_cnt", 32'(bc_m), 32'h0);
        @(negedge Clk);
        In_Valid = 1'b0;
        Rst_n    = 1'b1;

`ifdef SIPO_PARITY_EN
        send_word(4'b1010, 1'b0, 1'b0);
        chk("par_ok", 32'(pe_m), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(4'b1011, 1'b0, 1'b1);
        chk("par_err", 32'(pe_m), 32'h1);
        chk("par_po",  32'(po_m), 32'hB);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("par_once", 32'(pe_m), 32'h0);
`endif

        // Randomized traffic
        repeat (3000) begin
            cyc(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 99) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
